// File: rtl/reg_transfer_sequencer_if.sv
// Bus bundle between the two transfer requesters, the sequencer and the register file enables.
interface reg_transfer_sequencer_if #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned SEL_WIDTH = 4
);
    logic                 req0_valid;
    logic [SEL_WIDTH-1:0] req0_src;
    logic [SEL_WIDTH-1:0] req0_dst;
    logic                 req0_ba;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [SEL_WIDTH-1:0] req1_src;
    logic [SEL_WIDTH-1:0] req1_dst;
    logic                 req1_ba;
    logic                 req1_ready;
    logic [NUM_REGS-1:0]  reg_out_en;
    logic [NUM_REGS-1:0]  reg_in_en;
    logic                 BAout;
    logic                 busy;
    logic                 done;
    logic                 done_id;

    modport master (
        output req0_valid, req0_src, req0_dst, req0_ba,
        output req1_valid, req1_src, req1_dst, req1_ba,
        input  req0_ready, req1_ready,
        input  reg_out_en, reg_in_en, BAout, busy, done, done_id
    );

    modport slave (
        input  req0_valid, req0_src, req0_dst, req0_ba,
        input  req1_valid, req1_src, req1_dst, req1_ba,
        output req0_ready, req1_ready,
        output reg_out_en, reg_in_en, BAout, busy, done, done_id
    );
endinterface

// File: rtl/reg_transfer_sequencer.sv
// Register-to-register transfer sequencer: IDLE -> DRIVE -> WRITE -> DONE with a two-requester arbiter.
// Define XFER_RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module reg_transfer_sequencer #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned SEL_WIDTH = 4
) (
    input logic clock,
    input logic clear,
    reg_transfer_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WRITE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic                 ba_q, ba_d, owner_q, owner_d;
    logic [NUM_REGS-1:0]  out_en_q, out_en_d, in_en_q, in_en_d;
    logic                 baout_q, baout_d, busy_q, busy_d;
    logic                 done_q, done_d, done_id_q, done_id_d;
    logic                 grant, any_valid, idle_c;
`ifdef XFER_RR_ARB_EN
    logic                 prio_q, prio_d;
`endif

    // Out-of-range indices decode to an all-zero vector.
    function automatic logic [NUM_REGS-1:0] decode(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) v[i] = (32'(idx) == i);
        return v;
    endfunction

    // Arbiter: grant=1 selects requester 1.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        idle_c    = clear & (state_q == S_IDLE);
`ifdef XFER_RR_ARB_EN
        if (bus.req0_valid && bus.req1_valid) grant = prio_q;
        else                                  grant = ~bus.req0_valid;
`else
        grant = ~bus.req0_valid;
`endif
    end

    assign bus.req0_ready = idle_c & bus.req0_valid & ~grant;
    assign bus.req1_ready = idle_c & bus.req1_valid & grant;

    // Next state plus next values of the registered outputs, derived from the next state.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        ba_d      = ba_q;
        owner_d   = owner_q;
`ifdef XFER_RR_ARB_EN
        prio_d    = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_DRIVE;
                    owner_d = grant;
                    src_d   = grant ? bus.req1_src : bus.req0_src;
                    dst_d   = grant ? bus.req1_dst : bus.req0_dst;
                    ba_d    = grant ? bus.req1_ba  : bus.req0_ba;
                end
            end
            S_DRIVE: state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
`ifdef XFER_RR_ARB_EN
                prio_d  = ~owner_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        out_en_d  = '0;
        in_en_d   = '0;
        baout_d   = 1'b1;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        done_id_d = done_id_q;
        case (state_d)
            S_DRIVE: out_en_d = decode(src_d);
            S_WRITE: begin
                out_en_d = decode(src_d);
                in_en_d  = decode(dst_d);
                if (dst_d == '0) baout_d = ~ba_d;
            end
            S_DONE:  done_id_d = owner_d;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            ba_q      <= 1'b0;
            owner_q   <= 1'b0;
            out_en_q  <= '0;
            in_en_q   <= '0;
            baout_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
`ifdef XFER_RR_ARB_EN
            prio_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            ba_q      <= ba_d;
            owner_q   <= owner_d;
            out_en_q  <= out_en_d;
            in_en_q   <= in_en_d;
            baout_q   <= baout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
`ifdef XFER_RR_ARB_EN
            prio_q    <= prio_d;
`endif
        end
    end

    assign bus.reg_out_en = out_en_q;
    assign bus.reg_in_en  = in_en_q;
    assign bus.BAout      = baout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Self-checking bench for reg_transfer_sequencer: timeline model checked every negedge plus directed literal checks.
module tb_reg_transfer_sequencer;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned SEL_WIDTH = 4;
`ifdef XFER_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    reg_transfer_sequencer_if #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) bus ();
    reg_transfer_sequencer #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer accepted in cycle k occupies cycles k+1..k+3 (drive, write, done).
    int         cyc = 0;
    int         acc = -100;
    logic [3:0] m_src = '0, m_dst = '0;
    logic       m_ba = 1'b0, m_owner = 1'b0, pref = 1'b0, last_id = 1'b0;

    function automatic logic m_grant();
        if (bus.req0_valid && bus.req1_valid) return RR ? pref : 1'b0;
        return !bus.req0_valid;
    endfunction

    function automatic logic [15:0] hot(input logic [3:0] i);
        return 16'(1) << i;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            acc     <= -100;
            pref    <= 1'b0;
            last_id <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (cyc - acc == 3) begin
                pref    <= ~m_owner;
                last_id <= m_owner;
            end
            if (!((cyc - acc) inside {[1:3]}) && (bus.req0_valid || bus.req1_valid)) begin
                acc     <= cyc;
                m_owner <= m_grant();
                m_src   <= m_grant() ? bus.req1_src : bus.req0_src;
                m_dst   <= m_grant() ? bus.req1_dst : bus.req0_dst;
                m_ba    <= m_grant() ? bus.req1_ba  : bus.req0_ba;
            end
        end
    end

    int   ph;
    logic idle, g;
    always @(negedge clock) begin
        ph   = cyc - acc;
        idle = !(ph inside {[1:3]});
        g    = m_grant();
        chk("req0_ready", 32'(bus.req0_ready), 32'(clear && idle && bus.req0_valid && !g));
        chk("req1_ready", 32'(bus.req1_ready), 32'(clear && idle && bus.req1_valid && g));
        chk("reg_out_en", 32'(bus.reg_out_en), 32'((ph == 1 || ph == 2) ? hot(m_src) : 16'h0));
        chk("reg_in_en",  32'(bus.reg_in_en),  32'((ph == 2) ? hot(m_dst) : 16'h0));
        chk("BAout",      32'(bus.BAout),      32'((ph == 2 && m_dst == 4'd0) ? !m_ba : 1'b1));
        chk("busy",       32'(bus.busy),       32'(!idle));
        chk("done",       32'(bus.done),       32'(ph == 3));
        chk("done_id",    32'(bus.done_id),    32'((ph == 3) ? m_owner : last_id));
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input bit who, input bit v, input logic [3:0] s, input logic [3:0] d, input bit b);
        if (who) begin
            bus.req1_valid = v; bus.req1_src = s; bus.req1_dst = d; bus.req1_ba = b;
        end else begin
            bus.req0_valid = v; bus.req0_src = s; bus.req0_dst = d; bus.req0_ba = b;
        end
    endtask

    // Returns at the negedge of the handshake cycle, or after a bounded wait.
    task automatic wait_ready(input bit who, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (who ? bus.req1_ready : bus.req0_ready) got = 1'b1;
            else step();
        end
        chk("handshake", 32'(got), 32'(1));
    endtask

    task automatic xfer(input bit who, input logic [3:0] s, input logic [3:0] d, input bit b,
                        input logic [15:0] e_out, input logic [15:0] e_in, input bit e_ba);
        bit got;
        set_req(who, 1'b1, s, d, b);
        wait_ready(who, got);
        step();
        // Scramble the request fields to prove the latched copy is used.
        set_req(who, 1'b0, s ^ 4'hF, d ^ 4'hF, ~b);
        if (!got) return;
        @(negedge clock);
        chk("drive_out", 32'(bus.reg_out_en), 32'(e_out));
        chk("drive_in",  32'(bus.reg_in_en),  32'(0));
        step();
        @(negedge clock);
        chk("write_out", 32'(bus.reg_out_en), 32'(e_out));
        chk("write_in",  32'(bus.reg_in_en),  32'(e_in));
        chk("write_ba",  32'(bus.BAout),      32'(e_ba));
        step();
        @(negedge clock);
        chk("done_pulse", 32'(bus.done),    32'(1));
        chk("done_owner", 32'(bus.done_id), 32'(who));
        chk("done_out",   32'(bus.reg_out_en), 32'(0));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit         got;
        int         n;
        bit         r1seen;
        bit         done_seen;
        logic [3:0] owners;
        set_req(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        set_req(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        #1 clear = 1'b0;

        // Reset state with a pending request: nothing may be accepted.
        @(negedge clock);
        chk("rst_ready0", 32'(bus.req0_ready), 32'(0));
        chk("rst_out",    32'(bus.reg_out_en), 32'(0));
        chk("rst_in",     32'(bus.reg_in_en),  32'(0));
        chk("rst_BAout",  32'(bus.BAout),      32'(1));
        chk("rst_busy",   32'(bus.busy),       32'(0));
        chk("rst_done",   32'(bus.done),       32'(0));
        chk("rst_doneid", 32'(bus.done_id),    32'(0));
        step();
        step();
        clear = 1'b1;
        bus.req0_valid = 1'b0;
        step();

        xfer(1'b0, 4'd3, 4'd5, 1'b0, 16'h0008, 16'h0020, 1'b1);
        xfer(1'b1, 4'd7, 4'd0, 1'b1, 16'h0080, 16'h0001, 1'b0);

        // Both requesters valid continuously for four transfers.
        set_req(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        set_req(1'b1, 1'b1, 4'd3, 4'd4, 1'b0);
        n = 0; r1seen = 1'b0; owners = 4'b0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clock);
            if (bus.req1_ready) r1seen = 1'b1;
            if (bus.done) begin
                owners[n] = bus.done_id;
                n++;
            end
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("arb_count",  32'(n),      32'(4));
        chk("arb_owners", 32'(owners), RR ? 32'h0000_000A : 32'h0000_0000);
        chk("arb_req1",   32'(r1seen), 32'(RR));
        repeat (4) step();

        // Asynchronous clear during WRITE aborts the transfer.
        set_req(1'b0, 1'b1, 4'd2, 4'd4, 1'b0);
        wait_ready(1'b0, got);
        step();
        bus.req0_valid = 1'b0;
        step();
        @(negedge clock);
        chk("abort_write_in", 32'(bus.reg_in_en), 32'(16'h0010));
        #1 clear = 1'b0;
        #1;
        chk("abort_out",  32'(bus.reg_out_en), 32'(0));
        chk("abort_in",   32'(bus.reg_in_en),  32'(0));
        chk("abort_busy", 32'(bus.busy),       32'(0));
        step();
        clear = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.done) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 32'(0));
        step();

        xfer(1'b0, 4'd1, 4'd0, 1'b0, 16'h0002, 16'h0001, 1'b1);
        xfer(1'b0, 4'd9, 4'd9, 1'b0, 16'h0200, 16'h0200, 1'b1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
